uart_tag_reader: RTL

Parametrised UART receiver that requests and captures a multi-byte RFID UID from the external reader microcontroller. On a one-cycle `start` request it raises `TX` for a fixed number of sample ticks, then receives `NBYTES` 8N1 frames on `RX`. It assembles them into `tag`, and reports completion, framing error or timeout. It sits between the RFID reader link and the dispenser control logic that consumes `tag`.

---
 rtl/uart_tag_reader_if.sv | 29 ++
 rtl/uart_tag_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tag_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tag_reader_if : request/response bundle of the tag reader    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface uart_tag_reader_if #(
  parameter int NBYTES = 4
) ();
  logic                  start;
  logic                  RX;
  logic                  TX;
  logic [8*NBYTES-1:0]   tag;
  logic                  done;
  logic                  err;
  logic                  timeout;
  logic                  busy;

  modport master (
    output start, RX,
    input  TX, tag, done, err, timeout, busy
  );

  modport slave (
    input  start, RX,
    output TX, tag, done, err, timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tag_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tag_reader : requests and receives a multi-byte RFID UID     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module uart_tag_reader #(
  parameter int DIV           = 102,
  parameter int OVERSAMPLE    = 25,
  parameter int NBYTES        = 4,
  parameter int REQ_TICKS     = 31,
  parameter int TIMEOUT_TICKS = 50000
) (
  input  logic                clk,
  input  logic                RST,
  uart_tag_reader_if.slave    bus
);

  localparam int TAG_W    = 8 * NBYTES;
  localparam int HALF     = OVERSAMPLE / 2;
  localparam int DIV_W    = $clog2(DIV);
  localparam int TCNT_MAX = (REQ_TICKS > OVERSAMPLE) ? REQ_TICKS : OVERSAMPLE;
  localparam int TCNT_W   = $clog2(TCNT_MAX);
  localparam int TO_W     = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int BIDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t              state_q,    state_d;
  logic [DIV_W-1:0]    div_cnt_q,  div_cnt_d;
  logic                rx_meta_q,  rx_meta_d;
  logic                rx_sync_q,  rx_sync_d;
  logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;
  logic [2:0]          bit_cnt_q,  bit_cnt_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [7:0]          shift_q,    shift_d;
  logic [TAG_W-1:0]    stage_q,    stage_d;
  logic [TAG_W-1:0]    tag_q,      tag_d;
  logic                tx_q,       tx_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;
  logic                timeout_q,  timeout_d;

  logic tick;
  logic end_pulse;

  assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
  // busy has just fallen while an end pulse is up; a start in this cycle is dropped
  assign end_pulse = done_q | err_q | timeout_q;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    rx_meta_d  = bus.RX;
    rx_sync_d  = rx_meta_q;
    tick_cnt_d = tick_cnt_q;
    to_cnt_d   = to_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    stage_d    = stage_q;
    tag_d      = tag_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !end_pulse) begin
          state_d    = S_REQ;
          busy_d     = 1'b1;
          tx_d       = 1'b1;
          tick_cnt_d = '0;
        end
      end

      S_REQ: begin
        if (tick) begin
          if (tick_cnt_q == TCNT_W'(REQ_TICKS - 1)) begin
            tx_d       = 1'b0;
            byte_idx_d = '0;
            to_cnt_d   = '0;
            state_d    = S_WAIT;
          end else begin
            tick_cnt_d = tick_cnt_q + TCNT_W'(1);
          end
        end
      end

      S_WAIT: begin
        if (tick) begin
          if (!rx_sync_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else if (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
            timeout_d  = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            to_cnt_d   = to_cnt_q + TO_W'(1);
          end
        end
      end

      S_START: begin
        if (tick) begin
          if (tick_cnt_q == TCNT_W'(HALF - 1)) begin
            // a high level at mid start bit is a glitch; the timeout keeps running
            tick_cnt_d = '0;
            state_d    = rx_sync_q ? S_WAIT : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TCNT_W'(1);
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == TCNT_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCNT_W'(1);
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == TCNT_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            if (!rx_sync_q) begin
              err_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              // byte 0 lands in the most significant byte lane
              for (int i = 0; i < NBYTES; i++) begin
                if (byte_idx_q == BIDX_W'(i)) begin
                  stage_d[8*(NBYTES-1-i) +: 8] = shift_q;
                end
              end
              if (byte_idx_q == BIDX_W'(NBYTES - 1)) begin
                tag_d   = stage_d;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end else begin
                byte_idx_d = byte_idx_q + BIDX_W'(1);
                to_cnt_d   = '0;
                state_d    = S_WAIT;
              end
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      tick_cnt_q <= '0;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      stage_q    <= '0;
      tag_q      <= '0;
      tx_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      tick_cnt_q <= tick_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      stage_q    <= stage_d;
      tag_q      <= tag_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.TX      = tx_q;
  assign bus.tag     = tag_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = busy_q;

endmodule
`default_nettype wire
